// File: rtl/gate_chk_pkg.sv
// Shared types and the reference gate function used by the gate response checker.
package gate_chk_pkg;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_NAND = 2'b11
  } gate_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SETTLE = 2'b01,
    ST_CHECK  = 2'b10,
    ST_HOLD   = 2'b11
  } chk_state_e;

  localparam int unsigned TIMER_W = 4;

  function automatic logic gate_expect(input gate_op_e op, input logic [1:0] ab);
    logic res;
    case (op)
      OP_AND:  res = ab[1] & ab[0];
      OP_OR:   res = ab[1] | ab[0];
      OP_XOR:  res = ab[1] ^ ab[0];
      OP_NAND: res = ~(ab[1] & ab[0]);
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/gate_response_checker_settle_timer.sv
// Settle counter: cleared on every capture, counts stable cycles and flags
// when the last required stable cycle is being seen.
module settle_timer
  import gate_chk_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic inc_i,
  output logic done_o
);

  logic [TIMER_W-1:0] cnt_q;

  assign done_o = (cnt_q == TIMER_W'(SETTLE_CYCLES - 1));

  // Counter register; stops once done so it cannot wrap while held.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (inc_i && !done_o) begin
      cnt_q <= cnt_q + TIMER_W'(1);
    end
  end

endmodule

// File: rtl/gate_response_checker.sv
// Checks a 2-input gate's output once its inputs have been stable for
// SETTLE_CYCLES cycles, keeping saturating check/error counts and the first failing input.
module gate_response_checker
  import gate_chk_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       op,
  input  logic             a,
  input  logic             b,
  input  logic             x,
  output logic [CNT_W-1:0] check_count,
  output logic [CNT_W-1:0] error_count,
  output logic             mismatch,
  output logic             first_err_valid,
  output logic [1:0]       first_err_ab,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  chk_state_e       state_q;
  logic [1:0]       cap_ab_q;
  gate_op_e         cap_op_q;
  logic [CNT_W-1:0] check_q;
  logic [CNT_W-1:0] error_q;
  logic             mismatch_q;
  logic             fe_valid_q;
  logic [1:0]       fe_ab_q;
  logic             busy_q;

  logic [1:0] ab_s;
  logic       ab_chg_s;
  logic       expect_s;
  logic       tmr_clear_s;
  logic       tmr_inc_s;
  logic       tmr_done_s;

  assign ab_s     = {a, b};
  assign ab_chg_s = (ab_s != cap_ab_q);
  assign expect_s = gate_expect(cap_op_q, cap_ab_q);

  // Timer control: clear on any capture, count while SETTLE sees stable inputs.
  always_comb begin
    tmr_clear_s = 1'b0;
    tmr_inc_s   = 1'b0;
    if (en) begin
      case (state_q)
        ST_IDLE:   tmr_clear_s = 1'b1;
        ST_SETTLE: begin
          if (ab_chg_s) begin
            tmr_clear_s = 1'b1;
          end else begin
            tmr_inc_s = 1'b1;
          end
        end
        ST_CHECK, ST_HOLD: tmr_clear_s = ab_chg_s;
        default:   tmr_clear_s = 1'b1;
      endcase
    end else begin
      tmr_clear_s = 1'b0;
    end
  end

  settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear_i(tmr_clear_s),
    .inc_i  (tmr_inc_s),
    .done_o (tmr_done_s)
  );

  // Checker FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cap_ab_q   <= 2'b00;
      cap_op_q   <= OP_AND;
      check_q    <= '0;
      error_q    <= '0;
      mismatch_q <= 1'b0;
      fe_valid_q <= 1'b0;
      fe_ab_q    <= 2'b00;
      busy_q     <= 1'b0;
    end else if (!en) begin
      state_q    <= ST_IDLE;
      mismatch_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      mismatch_q <= 1'b0;
      busy_q     <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          cap_ab_q <= ab_s;
          cap_op_q <= gate_op_e'(op);
          state_q  <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (ab_chg_s) begin
            cap_ab_q <= ab_s;
          end else if (tmr_done_s) begin
            state_q <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (check_q != CNT_MAX) check_q <= check_q + CNT_W'(1);
          if (x != expect_s) begin
            mismatch_q <= 1'b1;
            if (error_q != CNT_MAX) error_q <= error_q + CNT_W'(1);
            if (!fe_valid_q) begin
              fe_valid_q <= 1'b1;
              fe_ab_q    <= cap_ab_q;
            end
          end
          // The comparison above used the old capture; a new value restarts settling.
          if (ab_chg_s) begin
            cap_ab_q <= ab_s;
            state_q  <= ST_SETTLE;
          end else begin
            state_q <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (ab_chg_s) begin
            cap_ab_q <= ab_s;
            state_q  <= ST_SETTLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign check_count     = check_q;
  assign error_count     = error_q;
  assign mismatch        = mismatch_q;
  assign first_err_valid = fe_valid_q;
  assign first_err_ab    = fe_ab_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_gate_response_checker.sv
// Bench for gate_response_checker: directed scenarios plus random stimulus,
// compared every cycle against a run-length reference model.
module tb_gate_response_checker;

  localparam int SC = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [1:0] op  = 2'b00;
  logic [1:0] ab  = 2'b00;
  logic       x   = 1'b0;

  logic [15:0] cc;
  logic [15:0] ec;
  logic        mis;
  logic        fev;
  logic [1:0]  feab;
  logic        bsy;
  logic [1:0]  s_cc;
  logic [1:0]  s_ec;
  logic        s_mis;
  logic        s_fev;
  logic [1:0]  s_feab;
  logic        s_bsy;

  always #5 clk = ~clk;

  gate_response_checker #(.SETTLE_CYCLES(SC), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .en(en), .op(op), .a(ab[1]), .b(ab[0]), .x(x),
    .check_count(cc), .error_count(ec), .mismatch(mis),
    .first_err_valid(fev), .first_err_ab(feab), .busy(bsy)
  );

  gate_response_checker #(.SETTLE_CYCLES(SC), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .op(op), .a(ab[1]), .b(ab[0]), .x(x),
    .check_count(s_cc), .error_count(s_ec), .mismatch(s_mis),
    .first_err_valid(s_fev), .first_err_ab(s_feab), .busy(s_bsy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: a session is a stretch of enabled cycles, a run is
  // a stretch of equal consecutive {a,b} samples inside a session.
  bit         m_in_sess;
  logic [1:0] m_op;
  logic [1:0] m_run_val;
  int         m_run_len;
  int         m_checks;
  int         m_errs;
  bit         m_mis;
  bit         m_fv;
  logic [1:0] m_fab;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic bit ref_gate(input logic [1:0] o, input logic [1:0] v);
    int s;
    int p;
    s = int'(v[1]) + int'(v[0]);
    p = int'(v[1]) * int'(v[0]);
    case (o)
      2'd0:    return (p == 1);
      2'd1:    return (s > 0);
      2'd2:    return (s == 1);
      default: return (p == 0);
    endcase
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_edge(input bit r, input bit e, input logic [1:0] o,
                            input logic [1:0] v, input bit xx);
    m_mis = 1'b0;
    if (r) begin
      m_in_sess = 1'b0; m_run_len = 0; m_checks = 0; m_errs = 0;
      m_fv = 1'b0; m_fab = 2'b00;
    end else if (!e) begin
      m_in_sess = 1'b0;
    end else if (!m_in_sess) begin
      m_in_sess = 1'b1; m_op = o; m_run_val = v; m_run_len = 1;
    end else begin
      // A run is checked exactly once: on the edge after SC+1 equal samples.
      if (m_run_len == SC + 1) begin
        m_checks++;
        if (xx != ref_gate(m_op, m_run_val)) begin
          m_errs++;
          m_mis = 1'b1;
          if (!m_fv) begin
            m_fv  = 1'b1;
            m_fab = m_run_val;
          end
        end
      end
      if (v == m_run_val) begin
        if (m_run_len < SC + 2) m_run_len++;
      end else begin
        m_run_val = v;
        m_run_len = 1;
      end
    end
  endtask

  task automatic step(input bit r, input bit e, input logic [1:0] o,
                      input logic [1:0] v, input bit xx);
    @(negedge clk);
    rst = r; en = e; op = o; ab = v; x = xx;
    @(posedge clk);
    model_edge(r, e, o, v, xx);
    #1;
    check_eq("check_count",     32'(cc),    32'(sat(m_checks, 65535)));
    check_eq("error_count",     32'(ec),    32'(sat(m_errs, 65535)));
    check_eq("mismatch",        32'(mis),   32'(m_mis));
    check_eq("first_err_valid", 32'(fev),   32'(m_fv));
    check_eq("first_err_ab",    32'(feab),  32'(m_fab));
    check_eq("busy",            32'(bsy),   32'(m_in_sess));
    check_eq("sat_check_count", 32'(s_cc),  32'(sat(m_checks, 3)));
    check_eq("sat_error_count", 32'(s_ec),  32'(sat(m_errs, 3)));
    check_eq("sat_mismatch",    32'(s_mis), 32'(m_mis));
    check_eq("sat_first_ab",    32'(s_feab), 32'(m_fab));
  endtask

  logic [1:0] pat [5];
  logic [1:0] rv;

  initial begin
    m_in_sess = 1'b0; m_run_len = 0; m_checks = 0; m_errs = 0;
    m_mis = 1'b0; m_fv = 1'b0; m_fab = 2'b00; m_op = 2'b00; m_run_val = 2'b00;

    // Reset, even with en high, must yield all-zero outputs.
    step(1'b1, 1'b1, 2'd3, 2'b11, 1'b1);
    step(1'b1, 1'b0, 2'd0, 2'b00, 1'b0);

    // AND, ab=11, x=1: first check lands on cycle SC+2, never a mismatch.
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, 2'd0, 2'b11, 1'b1);
      if (i == SC + 1) check_eq("and_first_check", 32'(cc), 32'd1);
    end
    check_eq("and_no_error", 32'(ec), 32'd0);

    // XOR, ab=11 with x=1 fails; then ab=10 with x=1 passes.
    step(1'b0, 1'b0, 2'd2, 2'b11, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 2'd2, 2'b11, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 2'd2, 2'b10, 1'b1);
    check_eq("xor_checks", 32'(cc), 32'd3);
    check_eq("xor_errors", 32'(ec), 32'd1);
    check_eq("xor_first_ab", 32'(feab), 32'd3);

    // Toggling inputs never settle; holding for SC+1 samples then checks.
    step(1'b0, 1'b0, 2'd1, 2'b00, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 2'd1, 2'(i % 2), 1'b1);
    check_eq("toggle_no_check", 32'(cc), 32'd3);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 2'd1, 2'b01, 1'b1);
    check_eq("toggle_then_hold", 32'(cc), 32'd4);

    // Drop en during SETTLE, then reset while in HOLD.
    step(1'b0, 1'b1, 2'd1, 2'b10, 1'b1);
    step(1'b0, 1'b0, 2'd1, 2'b10, 1'b1);
    check_eq("en_drop_busy", 32'(bsy), 32'd0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 2'd0, 2'b00, 1'b1);
    step(1'b1, 1'b1, 2'd0, 2'b00, 1'b1);
    check_eq("rst_hold_cnt", 32'(cc), 32'd0);

    // Narrow counters saturate at 3 after five failing AND patterns.
    pat[0] = 2'b00; pat[1] = 2'b01; pat[2] = 2'b10; pat[3] = 2'b00; pat[4] = 2'b01;
    for (int p = 0; p < 5; p++)
      for (int i = 0; i < SC + 2; i++) step(1'b0, 1'b1, 2'd0, pat[p], 1'b1);
    check_eq("sat_cc_final", 32'(s_cc), 32'd3);
    check_eq("sat_ec_final", 32'(s_ec), 32'd3);
    check_eq("wide_ec_final", 32'(ec), 32'd5);
    check_eq("sat_first_ab_final", 32'(s_feab), 32'd0);

    // Random stimulus against the model.
    step(1'b1, 1'b0, 2'd0, 2'b00, 1'b0);
    rv = 2'b00;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) rv = 2'($urandom_range(0, 3));
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 99) >= 4),
           2'($urandom_range(0, 3)), rv, 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
